// File: rtl/hdmi_pkg.sv
// Shared timing constants (640x480@60), sync polarities and sequencer state encoding
// for the HDMI output path.
package hdmi_pkg;

    localparam int unsigned H_ACT  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_ACT  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b0;

    localparam logic [23:0] FILL_RGB = 24'h000000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

endpackage

// File: rtl/video_pos_counter.sv
// Horizontal/vertical position counters with active-region and sync-window decode.
module video_pos_counter
    import hdmi_pkg::*;
#(
    parameter int unsigned HAct  = H_ACT,
    parameter int unsigned HFp   = H_FP,
    parameter int unsigned HSync = H_SYNC,
    parameter int unsigned HBp   = H_BP,
    parameter int unsigned VAct  = V_ACT,
    parameter int unsigned VFp   = V_FP,
    parameter int unsigned VSync = V_SYNC,
    parameter int unsigned VBp   = V_BP
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       adv_i,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       last_o,
    output logic       active_o,
    output logic       hsync_act_o,
    output logic       vsync_act_o
);

    localparam int unsigned HTot = HAct + HFp + HSync + HBp;
    localparam int unsigned VTot = VAct + VFp + VSync + VBp;

    localparam logic [9:0] HLast = 10'(HTot - 1);
    localparam logic [9:0] VLast = 10'(VTot - 1);

    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] HActW  = 11'(HAct);
    localparam logic [10:0] HSBeg  = 11'(HAct + HFp);
    localparam logic [10:0] HSEnd  = 11'(HAct + HFp + HSync);
    localparam logic [10:0] VActW  = 11'(VAct);
    localparam logic [10:0] VSBeg  = 11'(VAct + VFp);
    localparam logic [10:0] VSEnd  = 11'(VAct + VFp + VSync);

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [10:0] h_x, v_x;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (adv_i) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_x = {1'b0, h_q};
    assign v_x = {1'b0, v_q};

    assign h_o         = h_q;
    assign v_o         = v_q;
    assign last_o      = (h_q == HLast) && (v_q == VLast);
    assign active_o    = (h_x < HActW) && (v_x < VActW);
    assign hsync_act_o = (h_x >= HSBeg) && (h_x < HSEnd);
    assign vsync_act_o = (v_x >= VSBeg) && (v_x < VSEnd);

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// Start/stop video timing sequencer with a 2-stage pixel fetch pipeline feeding the
// TMDS encoders; sync, DE and RGB leave through the same two register stages.
module hdmi_video_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int unsigned HAct    = H_ACT,
    parameter int unsigned HFp     = H_FP,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBp     = H_BP,
    parameter int unsigned VAct    = V_ACT,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP,
    parameter bit          HsPol   = HS_POL,
    parameter bit          VsPol   = VS_POL,
    parameter logic [23:0] FillRgb = FILL_RGB
) (
    input  logic        pixclk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_underflow_i,
    output logic        pix_req_o,
    output logic [9:0]  pix_x_o,
    output logic [9:0]  pix_y_o,
    input  logic        pix_valid_i,
    input  logic [23:0] pix_rgb_i,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o,
    output logic        busy_o,
    output logic        underflow_o
);

    state_e      state_q, state_d;
    logic [9:0]  h, v;
    logic        last, active, hs_act, vs_act, running;
    logic        req1_q, hs1_q, vs1_q, fs1_q;
    logic        de_q, hsync_q, vsync_q, fs_q, uf_q, uf_d;
    logic [23:0] rgb_q, rgb_d;

    assign running = (state_q != StIdle);

    video_pos_counter #(
        .HAct  (HAct),
        .HFp   (HFp),
        .HSync (HSync),
        .HBp   (HBp),
        .VAct  (VAct),
        .VFp   (VFp),
        .VSync (VSync),
        .VBp   (VBp)
    ) u_pos (
        .clk_i       (pixclk_i),
        .rst_ni      (rst_ni),
        .adv_i       (running),
        .h_o         (h),
        .v_o         (v),
        .last_o      (last),
        .active_o    (active),
        .hsync_act_o (hs_act),
        .vsync_act_o (vs_act)
    );

    // Dropping en on the last position of a frame ends the frame right there.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en_i) state_d = StRun;
            StRun:  if (!en_i) state_d = last ? StIdle : StStop;
            StStop: begin
                if (en_i)      state_d = StRun;
                else if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pix_req_o = running & active;
    assign pix_x_o   = pix_req_o ? h : '0;
    assign pix_y_o   = pix_req_o ? v : '0;

    always_comb begin
        rgb_d = '0;
        if (req1_q) rgb_d = pix_valid_i ? pix_rgb_i : FillRgb;
        uf_d = uf_q;
        if (req1_q && !pix_valid_i) uf_d = 1'b1;
        else if (clr_underflow_i)   uf_d = 1'b0;
    end

    always_ff @(posedge pixclk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            req1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            fs1_q   <= 1'b0;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            hsync_q <= ~HsPol;
            vsync_q <= ~VsPol;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req1_q  <= pix_req_o;
            hs1_q   <= running & hs_act;
            vs1_q   <= running & vs_act;
            fs1_q   <= pix_req_o & (h == '0) & (v == '0);
            de_q    <= req1_q;
            rgb_q   <= rgb_d;
            hsync_q <= hs1_q ? HsPol : ~HsPol;
            vsync_q <= vs1_q ? VsPol : ~VsPol;
            fs_q    <= fs1_q;
            uf_q    <= uf_d;
        end
    end

    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = fs_q;
    assign busy_o        = running;
    assign underflow_o   = uf_q;

endmodule
